// File: rtl/ftm_pwm_core.sv
// ftm_pwm_core - FlexTimer-style counter / PWM core behind a simple register bus.
//
// A prescaled up-counter runs from CNTIN to MOD and wraps. Each channel can be
// disabled, do output-compare toggle, or produce edge-aligned PWM (high- or
// low-true). MOD, CNTIN and CnV are double-buffered: bus writes land in a
// buffer that is copied to the active copy on a wrap tick, or every cycle
// while the counter is stopped.
//
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   wr_en, rd_en   : single-cycle write / read strobes
//   addr [5:0]     : word address
//   wdata [31:0]   : write data
//   rdata [31:0]   : registered read data; holds until the next read
//   rvalid         : one-cycle pulse, the cycle after rd_en
//   ch_out         : registered channel outputs
//   irq            : (TOF & TOIE) | |(CHF & CHIE)
//
// Bus handshake: there is no back-pressure. A strobe is accepted in the cycle
// it is high; a write takes effect at the end of that cycle, a read returns
// data with rvalid one cycle later. A read and a write to the same address in
// one cycle return the pre-write value.
//
// Register map (unused upper bits read 0):
//   0x00 SC     [2:0] PS, [4:3] CLKS (01 = run), [6] TOIE, [7] TOF (W1C)
//   0x01 CNT    live counter; any write loads active CNTIN, clears prescaler
//   0x02 MOD    buffered
//   0x03 CNTIN  buffered
//   0x04 STATUS CHF mirror, write 1 clears
//   0x10+2n     CnSC [1:0] MODE, [6] CHIE, [7] CHF (W1C)
//   0x11+2n     CnV  buffered
module ftm_pwm_core #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [5:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic [NUM_CH-1:0] ch_out,
  output logic              irq
);

  localparam logic [5:0]       NCH     = 6'(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Status / control
  logic [2:0]  ps_q, ps_d;
  logic [1:0]  clks_q, clks_d;
  logic        toie_q, toie_d;
  logic        tof_q, tof_d;
  logic [6:0]  presc_q, presc_d;

  // Counter and buffered limits
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] mod_buf_q, mod_buf_d, mod_act_q, mod_act_d;
  logic [CNT_W-1:0] cntin_buf_q, cntin_buf_d, cntin_act_q, cntin_act_d;

  // Channels
  logic [NUM_CH-1:0][1:0]       mode_q, mode_d;
  logic [NUM_CH-1:0]            chie_q, chie_d;
  logic [NUM_CH-1:0]            chf_q, chf_d;
  logic [NUM_CH-1:0]            ch_out_q, ch_out_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cv_buf_q, cv_buf_d, cv_act_q, cv_act_d;

  // Read path
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q;

  // Address decode. Channel registers start at 0x10; bit 0 of the offset
  // selects CnV over CnSC, the rest is the channel index.
  logic [5:0] ch_off;
  logic [4:0] ch_n;
  logic       is_ch;
  logic       wr_sc, wr_cnt, wr_mod, wr_cntin, wr_status;

  assign ch_off    = addr - 6'd16;
  assign ch_n      = ch_off[5:1];
  assign is_ch     = (addr >= 6'd16) && ({1'b0, ch_n} < NCH);
  assign wr_sc     = wr_en && (addr == 6'h00);
  assign wr_cnt    = wr_en && (addr == 6'h01);
  assign wr_mod    = wr_en && (addr == 6'h02);
  assign wr_cntin  = wr_en && (addr == 6'h03);
  assign wr_status = wr_en && (addr == 6'h04);

  // Counter timing
  logic       running, tick, wrap, load;
  logic [6:0] presc_max;

  assign running   = (clks_q == 2'b01);
  assign presc_max = (7'd1 << ps_q) - 7'd1;
  assign tick      = running && (presc_q == presc_max);
  assign wrap      = tick && (cnt_q >= mod_act_q);
  // Buffers follow continuously while stopped so software sees its values
  // take effect before the counter is started.
  assign load      = wrap || !running;

  // Per-channel write hits and compare matches
  logic [NUM_CH-1:0] csc_hit, cv_hit, match;

  always_comb begin
    csc_hit = '0;
    cv_hit  = '0;
    match   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      csc_hit[n] = wr_en && is_ch && !ch_off[0] && (ch_n == 5'(n));
      cv_hit[n]  = wr_en && is_ch &&  ch_off[0] && (ch_n == 5'(n));
      match[n]   = tick && (mode_q[n] != 2'b00) && (cnt_q == cv_act_q[n]);
    end
  end

  // Next-state for control, counter and buffers
  always_comb begin
    ps_d   = ps_q;
    clks_d = clks_q;
    toie_d = toie_q;
    if (wr_sc) begin
      ps_d   = wdata[2:0];
      clks_d = wdata[4:3];
      toie_d = wdata[6];
    end
    // Set wins over a same-cycle W1C.
    tof_d = wrap || (tof_q && !(wr_sc && wdata[7]));

    if (!running || wr_cnt || tick) presc_d = '0;
    else                            presc_d = presc_q + 7'd1;

    cnt_d = cnt_q;
    if (wr_cnt)    cnt_d = cntin_act_q;
    else if (tick) cnt_d = wrap ? cntin_act_q : cnt_q + CNT_ONE;

    // A buffer write coinciding with a load passes straight to active.
    mod_buf_d   = wr_mod   ? wdata[CNT_W-1:0] : mod_buf_q;
    cntin_buf_d = wr_cntin ? wdata[CNT_W-1:0] : cntin_buf_q;
    mod_act_d   = load ? mod_buf_d   : mod_act_q;
    cntin_act_d = load ? cntin_buf_d : cntin_act_q;
  end

  // Next-state for channels
  always_comb begin
    mode_d   = mode_q;
    chie_d   = chie_q;
    chf_d    = chf_q;
    cv_buf_d = cv_buf_q;
    cv_act_d = cv_act_q;
    ch_out_d = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (csc_hit[n]) begin
        mode_d[n] = wdata[1:0];
        chie_d[n] = wdata[6];
      end
      chf_d[n] = match[n] ||
                 (chf_q[n] && !(csc_hit[n] && wdata[7]) && !(wr_status && wdata[n]));
      if (cv_hit[n]) cv_buf_d[n] = wdata[CNT_W-1:0];
      if (load)      cv_act_d[n] = cv_buf_d[n];
      case (mode_q[n])
        2'b01:   ch_out_d[n] = match[n] ? !ch_out_q[n] : ch_out_q[n];
        2'b10:   ch_out_d[n] = (cnt_q < cv_act_q[n]);
        2'b11:   ch_out_d[n] = !(cnt_q < cv_act_q[n]);
        default: ch_out_d[n] = 1'b0;
      endcase
    end
  end

  // Read mux, built from current register state (pre-write values)
  always_comb begin
    rdata_d = '0;
    case (addr)
      6'h00:   rdata_d = {24'd0, tof_q, toie_q, 1'b0, clks_q, ps_q};
      6'h01:   rdata_d = 32'(cnt_q);
      6'h02:   rdata_d = 32'(mod_buf_q);
      6'h03:   rdata_d = 32'(cntin_buf_q);
      6'h04:   rdata_d = 32'(chf_q);
      default: begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (is_ch && (ch_n == 5'(n))) begin
            if (ch_off[0]) rdata_d = 32'(cv_buf_q[n]);
            else           rdata_d = {24'd0, chf_q[n], chie_q[n], 4'd0, mode_q[n]};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q        <= '0;
      clks_q      <= '0;
      toie_q      <= 1'b0;
      tof_q       <= 1'b0;
      presc_q     <= '0;
      cnt_q       <= '0;
      mod_buf_q   <= '1;
      mod_act_q   <= '1;
      cntin_buf_q <= '0;
      cntin_act_q <= '0;
      mode_q      <= '0;
      chie_q      <= '0;
      chf_q       <= '0;
      ch_out_q    <= '0;
      cv_buf_q    <= '0;
      cv_act_q    <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      ps_q        <= ps_d;
      clks_q      <= clks_d;
      toie_q      <= toie_d;
      tof_q       <= tof_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      mod_buf_q   <= mod_buf_d;
      mod_act_q   <= mod_act_d;
      cntin_buf_q <= cntin_buf_d;
      cntin_act_q <= cntin_act_d;
      mode_q      <= mode_d;
      chie_q      <= chie_d;
      chf_q       <= chf_d;
      ch_out_q    <= ch_out_d;
      cv_buf_q    <= cv_buf_d;
      cv_act_q    <= cv_act_d;
      rvalid_q    <= rd_en;
      if (rd_en) rdata_q <= rdata_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign ch_out = ch_out_q;
  assign irq    = (tof_q && toie_q) || |(chf_q & chie_q);

  // Bits of wdata above the fields / counter width are don't-care.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

endmodule

// File: tb/tb_ftm_pwm_core.sv
module tb_ftm_pwm_core;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic              rd_en;
  logic [5:0]        addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rvalid;
  logic [NUM_CH-1:0] ch_out;
  logic              irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]       exp_q[$];
  string             name_q[$];
  logic              rec = 1'b0;
  logic [NUM_CH-1:0] hist[$];

  ftm_pwm_core #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid),
    .ch_out (ch_out),
    .irq    (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: records channel outputs when asked and scores every read.
  always @(negedge clk) begin
    if (rec) hist.push_back(ch_out);
    if (rvalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rvalid: got 0x%08h expected no read", rdata);
      end else begin
        chk(name_q.pop_front(), rdata, exp_q.pop_front());
      end
    end
  end

  function automatic int hi_cnt(input int ch, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (hist[i][ch] === 1'b1) c++;
    return c;
  endfunction

  function automatic int tog_cnt(input int ch, input int lo, input int hi);
    int c = 0;
    for (int i = lo + 1; i <= hi; i++) if (hist[i][ch] !== hist[i-1][ch]) c++;
    return c;
  endfunction

  // ---------------- driver tasks (called #1 after a rising edge) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [5:0] a, input logic [31:0] e);
    exp_q.push_back(e); name_q.push_back(nm);
    rd_en = 1'b1; addr = a;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic wrrd(input string nm, input logic [5:0] a, input logic [31:0] d,
                      input logic [31:0] e);
    exp_q.push_back(e); name_q.push_back(nm);
    wr_en = 1'b1; rd_en = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Reset defaults
    chk("rst_ch_out", 32'(ch_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rd("rst_sc",     6'h00, 32'h0);
    rd("rst_cnt",    6'h01, 32'h0);
    rd("rst_mod",    6'h02, 32'h0000_FFFF);
    rd("rst_cntin",  6'h03, 32'h0);
    rd("rst_status", 6'h04, 32'h0);
    rd("rst_c0sc",   6'h10, 32'h0);
    rd("rst_c0v",    6'h11, 32'h0);

    // Same-cycle write+read returns old value; upper bits truncated; rdata holds
    wrrd("wr_rd_same_c0v", 6'h11, 32'hABCD_1234, 32'h0);
    rd("c0v_after_wr", 6'h11, 32'h0000_1234);
    idle(2);
    chk("rdata_hold", rdata, 32'h0000_1234);
    chk("rvalid_pulse", 32'(rvalid), 32'h0);

    // Prescaler PS=2, CNTIN=4, MOD=7: count 4,5,6,7,4 every 4 clocks
    wr(6'h02, 32'd7);
    wr(6'h03, 32'd4);
    wr(6'h01, 32'd0);
    wr(6'h00, 32'h8A);
    rd("ps_cnt_4",  6'h01, 32'd4);
    idle(3);
    rd("ps_cnt_5",  6'h01, 32'd5);
    idle(3);
    rd("ps_cnt_6",  6'h01, 32'd6);
    idle(3);
    rd("ps_cnt_7",  6'h01, 32'd7);
    rd("ps_sc_no_tof", 6'h00, 32'h0A);
    idle(2);
    rd("ps_cnt_wrap", 6'h01, 32'd4);
    rd("ps_sc_tof",   6'h00, 32'h8A);
    rd("ps_cntin",    6'h03, 32'd4);
    wr(6'h00, 32'h00);

    // Basic PWM MOD=9, C0V=3, then buffered C0V=7 written at CNT=5
    wr(6'h02, 32'd9);
    wr(6'h03, 32'd0);
    wr(6'h10, 32'h02);
    wr(6'h11, 32'd3);
    wr(6'h01, 32'd0);
    hist.delete();
    wr(6'h00, 32'h88);
    rec = 1'b1;
    idle(35);
    wr(6'h11, 32'd7);
    rd("buf_c0v_readback", 6'h11, 32'd7);
    idle(24);
    rec = 1'b0;
    chk("pwm_hi_3_periods",  32'(hi_cnt(0, 1, 30)), 32'd9);
    chk("pwm_end_of_period", 32'(hist[10][0]), 32'h0);
    chk("pwm_start_period",  32'(hist[11][0]), 32'h1);
    chk("buf_old_period",    32'(hi_cnt(0, 31, 40)), 32'd3);
    chk("buf_new_period",    32'(hi_cnt(0, 41, 50)), 32'd7);
    chk("buf_next_period",   32'(hi_cnt(0, 51, 60)), 32'd7);

    // TOF / TOIE / irq
    chk("irq_no_toie", 32'(irq), 32'h0);
    wr(6'h00, 32'h40);
    chk("irq_toie", 32'(irq), 32'h1);
    rd("sc_tof_toie", 6'h00, 32'hC0);
    wr(6'h00, 32'hC0);
    chk("irq_tof_cleared", 32'(irq), 32'h0);
    rd("sc_tof_cleared", 6'h00, 32'h40);

    // Edge cases: C0V=0 -> always 0, C0V=10 > MOD -> always 1
    wr(6'h00, 32'h00);
    wr(6'h11, 32'd0);
    wr(6'h01, 32'd0);
    hist.delete();
    wr(6'h00, 32'h08);
    rec = 1'b1;
    idle(21);
    rec = 1'b0;
    chk("pwm_0pct", 32'(hi_cnt(0, 1, 20)), 32'd0);
    wr(6'h00, 32'h00);
    wr(6'h11, 32'd10);
    wr(6'h01, 32'd0);
    hist.delete();
    wr(6'h00, 32'h08);
    rec = 1'b1;
    idle(21);
    rec = 1'b0;
    chk("pwm_100pct", 32'(hi_cnt(0, 1, 20)), 32'd20);

    // Toggle mode on channel 1 with W1C collision on the match cycle
    wr(6'h00, 32'h00);
    wr(6'h10, 32'h80);
    wr(6'h12, 32'h41);
    wr(6'h13, 32'd5);
    wr(6'h02, 32'd9);
    wr(6'h03, 32'd0);
    wr(6'h04, 32'hFF);
    wr(6'h01, 32'd0);
    chk("tog_irq_idle", 32'(irq), 32'h0);
    hist.delete();
    wr(6'h00, 32'h88);
    rec = 1'b1;
    idle(15);
    wr(6'h04, 32'h02);                         // lands on the CNT==5 tick
    chk("tog_irq_set", 32'(irq), 32'h1);
    rd("chf_collision", 6'h04, 32'h02);
    wr(6'h04, 32'h02);
    chk("tog_irq_cleared", 32'(irq), 32'h0);
    rd("chf_cleared", 6'h04, 32'h00);
    idle(12);
    rec = 1'b0;
    chk("tog_count", 32'(tog_cnt(1, 0, 30)), 32'd3);
    rd("chf_reset_again", 6'h04, 32'h02);
    rd("c1sc_readback",   6'h12, 32'hC1);

    // Unmapped / out-of-range channel addresses
    rd("unmapped_3f", 6'h3F, 32'h0);
    rd("unmapped_05", 6'h05, 32'h0);
    rd("ch8_sc",      6'h20, 32'h0);
    wr(6'h20, 32'h03);
    wr(6'h21, 32'h55);
    rd("ch8_wr_ignored_sc", 6'h10, 32'h0);
    rd("ch8_wr_ignored_v",  6'h11, 32'd10);

    // Asynchronous reset mid-count
    idle(3);
    chk("irq_before_reset", 32'(irq), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_irq",   32'(irq), 32'h0);
    chk("async_rst_chout", 32'(ch_out), 32'h0);
    chk("async_rst_rdata", rdata, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    rd("post_rst_sc",   6'h00, 32'h0);
    rd("post_rst_cnt",  6'h01, 32'h0);
    idle(3);
    rd("post_rst_cnt_stopped", 6'h01, 32'h0);
    rd("post_rst_mod",  6'h02, 32'h0000_FFFF);
    rd("post_rst_c1sc", 6'h12, 32'h0);

    idle(3);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_reads: got %0d outstanding expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ftm_pwm_core.md
# ftm_pwm_core

Parametrised FlexTimer counter/PWM core. It sits behind the FTM register bus (`wr_en`/`rd_en`/address/data) and drives `NUM_CH` channel outputs. It provides a prescaled up-counter with programmable start (CNTIN) and modulo (MOD), and per-channel output-compare-toggle or edge-aligned PWM. MOD, CNTIN and CnV are double-buffered so they update glitch-free at counter wrap. Overflow and channel-match flags feed a single interrupt line.

## Interface

- `NUM_CH`, 8: number of channels, 1..16.
- `CNT_W`, 16: counter / MOD / CNTIN / CnV width, 8..32.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `wr_en` in 1: register write strobe, one cycle per access.
- `rd_en` in 1: register read strobe.
- `addr` in 6: word address.
- `wdata` in 32: write data.
- `rdata` out 32: read data, registered.
- `rvalid` out 1: `rdata` valid, one cycle after `rd_en`.
- `ch_out` out `NUM_CH`: channel outputs, registered.
- `irq` out 1: interrupt, `(TOF & TOIE) | |(CHF & CHIE)`.

## Operation

**Register map** (upper unused bits read 0):
- 0x00 SC: [2:0] PS, [4:3] CLKS (01 = run, others = stopped), [6] TOIE, [7] TOF (W1C).
- 0x01 CNT: read gives the live counter. Any write loads CNT with active CNTIN and clears the prescaler.
- 0x02 MOD: buffered.
- 0x03 CNTIN: buffered.
- 0x04 STATUS: [NUM_CH-1:0] CHF mirror. Write 1 clears.
- 0x10+2n CnSC: [1:0] MODE, [6] CHIE, [7] CHF (W1C).
- 0x11+2n CnV: buffered.
- Unmapped address or n ≥ `NUM_CH`: reads return 0, writes are ignored.

**Counter and flags:**
- Prescaler: a tick occurs every 2^PS clocks while CLKS=01. The prescaler clears when CLKS≠01.
- On a tick: if CNT ≥ MOD_active, then CNT ← CNTIN_active and TOF set; else CNT ← CNT+1. All arithmetic is modulo 2^CNT_W.
- CNTIN > MOD: CNT sits at CNTIN and TOF sets every tick.

**Buffering:**
- Writes to MOD, CNTIN and CnV land in buffer registers. Reads return the buffer.
- Buffer is copied to active on a wrap tick, or every cycle while CLKS≠01.
- A write in the same cycle as the load is copied through, so the new value becomes active.

**Channel modes:**
- 00: disabled, `ch_out`=0.
- 01: output compare. On a tick with CNT==CnV_active, `ch_out` toggles and CHF is set.
- 10: edge PWM high-true, `ch_out` = (CNT < CnV_active). CnV=CNTIN gives 0%; CnV > MOD gives 100%.
- 11: edge PWM low-true, the inverse of mode 10.
- Modes 10/11 also set CHF on a tick where CNT==CnV_active.
- Writing MODE takes effect on the next cycle.

**Flag collisions:** a W1C clear and a set event in the same cycle leave the flag set.

## Timing

- Reset values: CNT=0, MOD=all ones (active and buffer), CNTIN=0, CnV=0, SC=0, CnSC=0, `ch_out`=0, `rdata`=0, `rvalid`=0, `irq`=0.
- Reset asserted mid-count returns everything to reset values immediately. The counter restarts only after CLKS is written to 01.
- Read: `rd_en` in cycle t gives `rdata`/`rvalid` in t+1. `rdata` holds its value until the next read. `rvalid` is a single-cycle pulse.
- Write: takes effect at the end of the same cycle. CLKS=01 written in cycle t gives the first tick at the end of cycle t+2^PS.
- `wr_en`+`rd_en` to the same address in one cycle: read returns the pre-write value.
- `ch_out` is registered from the current CNT, so it lags CNT by one cycle.
- TOF/CHF are visible the cycle after the tick. `irq` is combinational from flag/enable registers.
- Back-to-back accesses are allowed every cycle.

## Test plan

- **Reset defaults:** reset, then read 0x00–0x04 and C0SC/C0V. Expected: SC=0, CNT=0, MOD=0xFFFF, CNTIN=0, STATUS=0, C0SC=0, C0V=0; `ch_out`=0, `irq`=0.
- **Basic PWM:** MOD=9, CNTIN=0, C0SC=MODE 10, C0V=3, SC=CLKS 01 / PS 0. Expected: `ch_out[0]` high 3 of every 10 cycles; TOF sets every 10 cycles; `irq` only after TOIE=1. Writing TOF=1 clears it.
- **Prescaler and CNTIN:** PS=2, CNTIN=4, MOD=7. Expected: CNT steps 4,5,6,7,4,… changing every 4 clocks; TOF at each 7→4 wrap.
- **Buffered update:** while running with MOD=9, C0V=3, write C0V=7 at CNT=5. Expected: the current period keeps 3-cycle high; the next period is 7-cycle high. Readback of C0V returns 7 immediately.
- **Toggle and flag collision:** C1SC=MODE 01 / CHIE, C1V=5, MOD=9. Expected: `ch_out[1]` toggles once per 10 ticks; CHF[1] sets and `irq`=1. A STATUS W1C issued in the same cycle as the match leaves CHF[1]=1.
- **Edge cases:** C0V=0 gives constant 0; C0V=10 with MOD=9 gives constant 1; an unmapped address 0x3F reads 0; with `NUM_CH`=8, address 0x20 reads 0.
